// File: rtl/stereo_pattern_source.sv
// stereo_pattern_source: synthetic stereo video source with known disparity; `define STEREO_SRC_NOISE_EN adds LFSR noise on pixel_right[1:0]
module stereo_pattern_source #(
    parameter int H_ACTIVE         = 1280,
    parameter int H_FP             = 110,
    parameter int H_SYNC           = 40,
    parameter int H_BP             = 220,
    parameter int V_ACTIVE         = 720,
    parameter int V_FP             = 5,
    parameter int V_SYNC           = 5,
    parameter int V_BP             = 20,
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int MAX_DISP         = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [5:0] disparity,
    input  logic [1:0] pattern_sel,
    output logic       de_out,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic [7:0] pixel_left,
    output logic [7:0] pixel_right,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    // right-image column is kept at least 8 bits so ramp/texture see the full shifted coordinate
    localparam int XW = (HW + 1 > 8) ? HW + 1 : 8;
    localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);
    localparam logic SYNC_OFF = !SYNC_ON;
    localparam logic [5:0] DISP_MAX = 6'(MAX_DISP);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic [5:0] disp_q;
    logic [1:0] pattern_q;
    logic h_wrap, v_wrap, run, latch, de_c, hs_c, vs_c, fs_c;
    logic [XW-1:0] x, xr;
    logic [7:0] y, left_c, right_c, noise;

    function automatic logic [7:0] pix(input logic [1:0] p, input logic [XW-1:0] c, input logic [7:0] r);
        pix = p == 2'd0 ? (c[7:0] ^ {c[2:0], c[7:3]}) + r :
              p == 2'd1 ? c[7:0] :
              p == 2'd2 ? 8'h80 :
              (c >= XW'(64) && c < XW'(128)) ? 8'hFF : 8'h00;
    endfunction

    // next state and counters; parameters latch whenever counters (re)enter (0,0) in RUN
    always_comb begin
        h_wrap = h_cnt == HW'(H_TOTAL - 1);
        v_wrap = v_cnt == VW'(V_TOTAL - 1);
        run = state == RUN;
        latch = run ? (h_wrap && v_wrap && enable) : enable;
        state_nxt = ((run && !(h_wrap && v_wrap)) || enable) ? RUN : IDLE;
        h_nxt = (!run || h_wrap) ? '0 : h_cnt + 1'b1;
        v_nxt = !run ? '0 : h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
    end

    // decode of the current counter state into the values registered onto the outputs
    always_comb begin
        de_c = run && h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
        hs_c = run && h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC);
        vs_c = run && v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC);
        fs_c = run && h_cnt == '0 && v_cnt == '0;
        x = XW'(h_cnt);
        xr = x + XW'(disp_q);
        y = 8'(v_cnt);
        left_c = de_c ? pix(pattern_q, x, y) : 8'h00;
        right_c = de_c ? pix(pattern_q, xr, y) ^ noise : 8'h00;
    end

`ifdef STEREO_SRC_NOISE_EN
    logic [7:0] lfsr, lfsr_cur;

    // the frame's first de cycle uses the seed directly so every frame's noise is identical
    always_comb begin
        lfsr_cur = fs_c ? 8'hA5 : lfsr;
        noise = {6'b0, lfsr_cur[1:0]};
    end

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR stepping once per de cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= 8'hA5;
        else if (de_c) lfsr <= {lfsr_cur[6:0], lfsr_cur[7] ^ lfsr_cur[5] ^ lfsr_cur[4] ^ lfsr_cur[3]};
`else
    assign noise = 8'h00;
`endif

    // generator state, counters and per-frame parameters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            disp_q <= '0;
            pattern_q <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (latch) begin
                disp_q <= disparity > DISP_MAX ? DISP_MAX : disparity;
                pattern_q <= pattern_sel;
            end
        end
    end

    // output registers, all one cycle behind the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out <= 1'b0;
            h_sync_out <= SYNC_OFF;
            v_sync_out <= SYNC_OFF;
            pixel_left <= 8'h00;
            pixel_right <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            de_out <= de_c;
            h_sync_out <= hs_c ? SYNC_ON : SYNC_OFF;
            v_sync_out <= vs_c ? SYNC_ON : SYNC_OFF;
            pixel_left <= left_c;
            pixel_right <= right_c;
            frame_start <= fs_c;
        end
    end
endmodule

// File: tb/tb_stereo_pattern_source.sv
// tb_stereo_pattern_source: scoreboard plus table-driven checks of the stereo pattern source
module tb_stereo_pattern_source;
    logic clk = 1'b0;
    logic rst_n, enable, de_out, h_sync_out, v_sync_out, frame_start;
    logic [5:0] disparity;
    logic [1:0] pattern_sel;
    logic [7:0] pixel_left, pixel_right;
    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic run;
        logic [7:0] h, v;
        logic de, hs, vs, fs;
        logic [7:0] l, r;
    } exp_t;

    typedef struct {
        int pat, disp, col, row;
        logic [7:0] el, er;
    } vec_t;

    exp_t q[$];
    exp_t last;
    vec_t tbl[9];

    stereo_pattern_source #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .disparity(disparity),
        .pattern_sel(pattern_sel), .de_out(de_out), .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out), .pixel_left(pixel_left), .pixel_right(pixel_right),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    function automatic logic [7:0] mpix(input int p, input int c, input int y);
        logic [7:0] a, rot;
        a = 8'(c);
        rot = (a >> 3) | (a << 5);
        if (p == 1) return a;
        if (p == 2) return 8'h80;
        if (p == 3) return (c >= 64 && c < 128) ? 8'hFF : 8'h00;
        return (a ^ rot) + 8'(y);
    endfunction

    // reference timing model: push expectation for the upcoming edge, then advance
    initial begin
        int mh, mv, md, mp;
        bit mrun;
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mrun = 0; mh = 0; mv = 0; md = 0; mp = 0;
                q.delete();
                last = '0;
            end else begin
                e.run = mrun;
                e.h = 8'(mh);
                e.v = 8'(mv);
                e.de = mrun && mh < 16 && mv < 4;
                e.hs = mrun && mh >= 18 && mh < 21;
                e.vs = mrun && mv == 5;
                e.fs = mrun && mh == 0 && mv == 0;
                e.l = e.de ? mpix(mp, mh, mv) : 8'h00;
                e.r = e.de ? mpix(mp, mh + md, mv) : 8'h00;
                q.push_back(e);
                if (!mrun) begin
                    if (enable) begin mrun = 1; md = int'(disparity); mp = int'(pattern_sel); end
                end else if (mh == 23) begin
                    mh = 0;
                    if (mv == 6) begin
                        mv = 0;
                        if (enable) begin md = int'(disparity); mp = int'(pattern_sel); end
                        else mrun = 0;
                    end else mv++;
                end else mh++;
            end
        end
    end

    // scoreboard consumer
    initial forever begin
        @(negedge clk);
        if (rst_n && q.size() > 0) begin
            last = q.pop_front();
            chk($sformatf("sb h=%0d v=%0d", last.h, last.v),
                {4'b0, de_out, h_sync_out, v_sync_out, frame_start, pixel_left, pixel_right},
                {4'b0, last.de, last.hs, last.vs, last.fs, last.l, last.r});
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (!frame_start && n < 400);
        if (n >= 400) begin total++; bad++; $display("FAIL wait_frame timeout"); end
    endtask

    task automatic check_at(input string nm, input int col, input int row, input logic [7:0] el, input logic [7:0] er);
        int n = 0;
        while (!(last.run && int'(last.h) == col && int'(last.v) == row) && n < 400) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 400) begin total++; bad++; $display("FAIL %s timeout", nm); end
        chk(nm, {16'b0, pixel_left, pixel_right}, {16'b0, el, er});
    endtask

    initial begin
        int n;
        bit saw_vs;
        tbl[0] = '{1, 3, 0, 0, 8'h00, 8'h03};
        tbl[1] = '{1, 3, 15, 0, 8'h0F, 8'h12};
        tbl[2] = '{0, 0, 5, 0, 8'hA5, 8'hA5};
        tbl[3] = '{0, 5, 0, 0, 8'h00, 8'hA5};
        tbl[4] = '{0, 0, 1, 2, 8'h23, 8'h23};
        tbl[5] = '{2, 3, 2, 1, 8'h80, 8'h80};
        tbl[6] = '{3, 63, 1, 0, 8'h00, 8'hFF};
        tbl[7] = '{3, 63, 0, 3, 8'h00, 8'h00};
        tbl[8] = '{1, 63, 5, 0, 8'h05, 8'h44};
        rst_n = 1'b0; enable = 1'b0; disparity = 6'd0; pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        #1 chk("reset", {26'b0, de_out, h_sync_out, v_sync_out, frame_start, |pixel_left, |pixel_right}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pattern_sel = 2'd1; disparity = 6'd3; enable = 1'b1;
        @(negedge clk); #1 chk("first_idle", {31'b0, de_out}, 32'h0);
        @(negedge clk); #1 chk("first_de", {30'b0, de_out, frame_start}, 32'h3);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!frame_start && n < 400);
        chk("fs_period", n, 168);
        foreach (tbl[i]) begin
            pattern_sel = 2'(tbl[i].pat);
            disparity = 6'(tbl[i].disp);
            wait_frame();
            wait_frame();
            check_at($sformatf("tbl%0d", i), tbl[i].col, tbl[i].row, tbl[i].el, tbl[i].er);
        end
        pattern_sel = 2'd1; disparity = 6'd3;
        wait_frame();
        wait_frame();
        check_at("latch_r1", 3, 1, 8'h03, 8'h06);
        disparity = 6'd7;
        check_at("latch_same", 3, 2, 8'h03, 8'h06);
        wait_frame();
        check_at("latch_next", 3, 2, 8'h03, 8'h0A);
        check_at("drop_row1", 0, 1, 8'h00, 8'h07);
        enable = 1'b0;
        saw_vs = 0;
        repeat (200) begin @(negedge clk); #1; if (v_sync_out) saw_vs = 1; end
        chk("drop_vs_seen", {31'b0, saw_vs}, 32'h1);
        repeat (10) begin
            @(negedge clk);
            #1 chk("idle", {16'b0, 2'b0, de_out, h_sync_out, v_sync_out, frame_start, 2'b0, pixel_left | pixel_right}, 32'h0);
        end
        enable = 1'b1;
        @(negedge clk); #1 chk("restart_idle", {31'b0, de_out}, 32'h0);
        @(negedge clk); #1 chk("restart_00", {14'b0, de_out, frame_start, pixel_left, pixel_right}, {14'b0, 2'b11, 8'h00, 8'h07});
        check_at("pre_rst", 7, 0, 8'h07, 8'h0E);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {16'b0, 2'b0, de_out, h_sync_out, v_sync_out, frame_start, 2'b0, pixel_left | pixel_right}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1 chk("rst_restart_idle", {31'b0, de_out}, 32'h0);
        @(negedge clk); #1 chk("rst_restart_00", {14'b0, de_out, frame_start, pixel_left, pixel_right}, {14'b0, 2'b11, 8'h00, 8'h07});
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
